// File: rtl/spi_sclk_gen_if.sv
// rtl/spi_sclk_gen_if.sv - config, start/abort and SCLK/strobe bundle between controller and SCLK generator
interface spi_sclk_gen_if #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 6
);
  logic             i_cfg_we;
  logic [DIV_W-1:0] i_cfg_div;
  logic [LEN_W-1:0] i_cfg_len;
  logic             i_cfg_cpol;
  logic             i_cfg_cpha;
  logic             i_start_n;
  logic             i_abort;
  logic             o_ready;
  logic             o_clk;
  logic             o_sample;
  logic             o_shift;

  // Controller side: programs the generator and consumes SCLK plus strobes
  modport master (
    output i_cfg_we, i_cfg_div, i_cfg_len, i_cfg_cpol, i_cfg_cpha, i_start_n, i_abort,
    input  o_ready, o_clk, o_sample, o_shift
  );

  // Generator side
  modport slave (
    input  i_cfg_we, i_cfg_div, i_cfg_len, i_cfg_cpol, i_cfg_cpha, i_start_n, i_abort,
    output o_ready, o_clk, o_sample, o_shift
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - programmable SPI SCLK generator with CPOL/CPHA, burst length, strobes and abort
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 6
) (
  input logic          i_clk,
  input logic          i_rst_n,
  spi_sclk_gen_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;     // effective divisor, always even and >= 2
  logic [LEN_W-1:0] len_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [DIV_W-2:0] half_cnt;  // i_clk cycles spent in the current SCLK half period
  logic [LEN_W:0]   edge_cnt;  // SCLK edges already produced in this burst
  logic             ready_q;
  logic             clk_q;
  logic             sample_q;
  logic             shift_q;

  logic [DIV_W-1:0] div_in;
  logic [DIV_W-1:0] half_m1;
  logic [LEN_W:0]   edge_nxt;
  logic [LEN_W:0]   edge_last;
  logic             half_done;
  logic             leading;
  logic             start_ok;

  // Incoming divisor: drop the LSB so both SCLK halves are equal, and clamp to the fastest legal rate
  always_comb begin
    div_in = bus.i_cfg_div & ~DIV_W'(1);
    if (div_in < DIV_W'(2)) begin
      div_in = DIV_W'(2);
    end
  end

  assign half_m1   = (div_q >> 1) - DIV_W'(1);
  assign half_done = ({1'b0, half_cnt} == half_m1);
  assign edge_nxt  = edge_cnt + (LEN_W+1)'(1);
  assign edge_last = {len_q, 1'b0};
  // The edge about to be produced is odd-numbered (leading) when the count so far is even
  assign leading   = ~edge_cnt[0];
  // A config write in the same cycle wins over start; a zero-length burst never starts
  assign start_ok  = !bus.i_start_n && !bus.i_cfg_we && !bus.i_abort && (len_q != '0);

  // Burst sequencer: config capture, half-period timing, edge counting and registered strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      div_q    <= DIV_W'(2);
      len_q    <= LEN_W'(8);
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
      ready_q  <= 1'b1;
      clk_q    <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_cfg_we) begin
            div_q  <= div_in;
            len_q  <= bus.i_cfg_len;
            cpol_q <= bus.i_cfg_cpol;
            cpha_q <= bus.i_cfg_cpha;
            clk_q  <= bus.i_cfg_cpol;
          end else if (start_ok) begin
            state    <= ST_RUN;
            ready_q  <= 1'b0;
            clk_q    <= cpol_q;
            half_cnt <= '0;
            edge_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (bus.i_abort) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            clk_q    <= cpol_q;
            half_cnt <= '0;
            edge_cnt <= '0;
          end else if (half_done) begin
            clk_q    <= ~clk_q;
            half_cnt <= '0;
            edge_cnt <= edge_nxt;
            // cpha=0 samples on leading edges, cpha=1 on trailing edges; shift takes the other one
            sample_q <= leading ^ cpha_q;
            shift_q  <= ~(leading ^ cpha_q);
            if (edge_nxt == edge_last) begin
              // An even number of toggles leaves SCLK back at its idle level
              state    <= ST_IDLE;
              ready_q  <= 1'b1;
              edge_cnt <= '0;
            end
          end else begin
            half_cnt <= half_cnt + (DIV_W-1)'(1);
          end
        end
      endcase
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_clk    = clk_q;
  assign bus.o_sample = sample_q;
  assign bus.o_shift  = shift_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - self-checking bench for spi_sclk_gen against an event-list reference model
module tb_spi_sclk_gen;
  localparam int DIV_W = 8;
  localparam int LEN_W = 6;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  spi_sclk_gen_if #(.DIV_W(DIV_W), .LEN_W(LEN_W)) bus ();

  spi_sclk_gen #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Observed burst, as offsets in i_clk cycles from the edge that accepted start
  int   cap_tog[$];
  int   cap_samp[$];
  int   cap_shift[$];
  int   cap_busy;
  bit   cap_done;
  logic cap_end_clk;

  // Expected burst from the reference model
  int exp_tog[$];
  int exp_samp[$];
  int exp_shift[$];
  int exp_busy;

  function automatic int eff_div(input int d);
    int e;
    e = d - (d % 2);
    if (e < 2) e = 2;
    return e;
  endfunction

  // Edge k of 2*len lands k*half cycles after start; odd k is the leading edge
  function automatic void build_expect(input int div, input int len, input int cpha);
    int half;
    half = eff_div(div) / 2;
    exp_tog.delete();
    exp_samp.delete();
    exp_shift.delete();
    exp_busy = len * eff_div(div);
    for (int k = 1; k <= 2 * len; k++) begin
      exp_tog.push_back(k * half);
      if (((k % 2) == 1) == (cpha == 0)) exp_samp.push_back(k * half);
      else exp_shift.push_back(k * half);
    end
  endfunction

  // -1 when equal, -2 on size difference, otherwise first differing index
  function automatic int qdiff(input int a[$], input int b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  task automatic write_cfg(input int div, input int len, input bit cpol, input bit cpha);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_div  = DIV_W'(div);
    bus.i_cfg_len  = LEN_W'(len);
    bus.i_cfg_cpol = cpol;
    bus.i_cfg_cpha = cpha;
    @(negedge i_clk);
    bus.i_cfg_we   = 1'b0;
  endtask

  // Starts a burst and records it until o_ready returns; we_at >= 0 pulses a config write mid-burst
  task automatic capture(input int budget, input bit hold, input int we_at);
    logic prev;
    int   off;
    cap_tog.delete();
    cap_samp.delete();
    cap_shift.delete();
    cap_done = 1'b0;
    cap_busy = 0;
    prev = bus.o_clk;
    bus.i_start_n = 1'b0;
    @(negedge i_clk);
    if (!hold) bus.i_start_n = 1'b1;
    off = 0;
    while (off <= budget) begin
      if (bus.o_clk !== prev) cap_tog.push_back(off);
      if (bus.o_sample === 1'b1) cap_samp.push_back(off);
      if (bus.o_shift === 1'b1) cap_shift.push_back(off);
      prev = bus.o_clk;
      if (bus.o_ready === 1'b1) begin
        cap_done = 1'b1;
        break;
      end
      cap_busy++;
      if (off == we_at) begin
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_div  = DIV_W'(100);
        bus.i_cfg_len  = LEN_W'(20);
        bus.i_cfg_cpol = 1'b1;
        bus.i_cfg_cpha = 1'b1;
      end else begin
        bus.i_cfg_we = 1'b0;
      end
      @(negedge i_clk);
      off++;
    end
    bus.i_cfg_we = 1'b0;
    cap_end_clk = bus.o_clk;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (16) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
    checks++;
    if (bus.o_clk !== 1'b0) begin errors++; $display("FAIL reset_clk got %b want 0", bus.o_clk); end
    checks++;
    if ({bus.o_sample, bus.o_shift} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes got %b%b want 00", bus.o_sample, bus.o_shift);
    end
  endtask

  task automatic test_bursts;
    int  t_div[4]  = '{250, 2, 5, 1};
    int  t_len[4]  = '{8, 8, 4, 6};
    bit  t_cpol[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit  t_cpha[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      int div, len, d;
      bit cpol, cpha;
      if (i < 4) begin
        div = t_div[i]; len = t_len[i]; cpol = t_cpol[i]; cpha = t_cpha[i];
      end else begin
        div  = int'($urandom_range(0, 40));
        len  = int'($urandom_range(1, 12));
        cpol = 1'($urandom_range(0, 1));
        cpha = 1'($urandom_range(0, 1));
      end
      write_cfg(div, len, cpol, cpha);
      @(negedge i_clk);
      checks++;
      if (bus.o_clk !== cpol) begin
        errors++; $display("FAIL idle_clk[%0d] got %b want %b", i, bus.o_clk, cpol);
      end
      build_expect(div, len, cpha);
      capture(exp_busy + 20, 1'b0, -1);
      checks++;
      if (!cap_done || cap_busy != exp_busy) begin
        errors++; $display("FAIL busy[%0d] div=%0d len=%0d got %0d want %0d", i, div, len, cap_busy, exp_busy);
      end
      checks++;
      d = qdiff(cap_tog, exp_tog);
      if (d != -1) begin
        errors++; $display("FAIL toggles[%0d] got %0d edges (diff %0d) want %0d", i, cap_tog.size(), d, exp_tog.size());
      end
      checks++;
      d = qdiff(cap_samp, exp_samp);
      if (d != -1) begin
        errors++; $display("FAIL sample[%0d] got %0d strobes (diff %0d) want %0d", i, cap_samp.size(), d, exp_samp.size());
      end
      checks++;
      d = qdiff(cap_shift, exp_shift);
      if (d != -1) begin
        errors++; $display("FAIL shift[%0d] got %0d strobes (diff %0d) want %0d", i, cap_shift.size(), d, exp_shift.size());
      end
      checks++;
      if (cap_end_clk !== cpol) begin
        errors++; $display("FAIL end_clk[%0d] got %b want %b", i, cap_end_clk, cpol);
      end
    end
  endtask

  task automatic test_config_busy;
    int d;
    write_cfg(5, 4, 1'b0, 1'b0);
    build_expect(5, 4, 0);
    capture(exp_busy + 20, 1'b0, 3);
    checks++;
    if (cap_busy != exp_busy) begin
      errors++; $display("FAIL busy_write_len got %0d want %0d", cap_busy, exp_busy);
    end
    checks++;
    d = qdiff(cap_tog, exp_tog);
    if (d != -1) begin errors++; $display("FAIL busy_write_toggles got diff %0d want -1", d); end
    @(negedge i_clk);
    checks++;
    if (bus.o_clk !== 1'b0) begin errors++; $display("FAIL busy_write_cpol got %b want 0", bus.o_clk); end
    capture(exp_busy + 20, 1'b0, -1);
    checks++;
    if (cap_busy != exp_busy) begin
      errors++; $display("FAIL stored_cfg_len got %0d want %0d", cap_busy, exp_busy);
    end
    checks++;
    d = qdiff(cap_samp, exp_samp);
    if (d != -1) begin errors++; $display("FAIL stored_cfg_cpha got diff %0d want -1", d); end
    // Config write and start presented together: the write wins, no burst
    bus.i_cfg_we  = 1'b1;
    bus.i_start_n = 1'b0;
    @(negedge i_clk);
    bus.i_cfg_we  = 1'b0;
    bus.i_start_n = 1'b1;
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL cfg_priority got %b want 1", bus.o_ready); end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    write_cfg(4, 3, 1'b0, 1'b0);
    build_expect(4, 3, 0);
    for (int b = 0; b < 3; b++) begin
      capture(exp_busy + 20, 1'b1, -1);
      checks++;
      if (!cap_done || cap_busy != exp_busy) begin
        errors++; $display("FAIL b2b_burst[%0d] got %0d want %0d", b, cap_busy, exp_busy);
      end
      checks++;
      if (qdiff(cap_tog, exp_tog) != -1) begin
        errors++; $display("FAIL b2b_toggles[%0d] got %0d edges want %0d", b, cap_tog.size(), exp_tog.size());
      end
    end
    bus.i_start_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_release got %b want 1", bus.o_ready); end
  endtask

  task automatic test_len_zero;
    int not_ready;
    not_ready = 0;
    write_cfg(4, 0, 1'b0, 1'b0);
    bus.i_start_n = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      if (bus.o_ready !== 1'b1 || bus.o_clk !== 1'b0) not_ready++;
    end
    bus.i_start_n = 1'b1;
    checks++;
    if (not_ready != 0) begin errors++; $display("FAIL len_zero got %0d busy cycles want 0", not_ready); end
  endtask

  task automatic test_abort;
    int half, toggles, guard;
    logic prev;
    write_cfg(100, 8, 1'b1, 1'b0);
    half = eff_div(100) / 2;
    prev = bus.o_clk;
    toggles = 0;
    guard = 0;
    bus.i_start_n = 1'b0;
    @(negedge i_clk);
    bus.i_start_n = 1'b1;
    while (toggles < 5 && guard < 2000) begin
      if (bus.o_clk !== prev) toggles++;
      prev = bus.o_clk;
      if (toggles < 5) @(negedge i_clk);
      guard++;
    end
    checks++;
    if (toggles != 5) begin errors++; $display("FAIL abort_reach_edge5 got %0d want 5", toggles); end
    checks++;
    if (bus.o_clk !== 1'b0) begin errors++; $display("FAIL abort_pre_clk got %b want 0", bus.o_clk); end
    // Land the abort on the same cycle as edge 6 so it has to win over the edge
    repeat (half - 1) @(negedge i_clk);
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", bus.o_ready); end
    checks++;
    if (bus.o_clk !== 1'b1) begin errors++; $display("FAIL abort_clk got %b want 1", bus.o_clk); end
    checks++;
    if ({bus.o_sample, bus.o_shift} !== 2'b00) begin
      errors++; $display("FAIL abort_strobes got %b%b want 00", bus.o_sample, bus.o_shift);
    end
    @(negedge i_clk);
    build_expect(100, 8, 0);
    capture(exp_busy + 20, 1'b0, -1);
    checks++;
    if (cap_busy != exp_busy || qdiff(cap_tog, exp_tog) != -1) begin
      errors++; $display("FAIL after_abort got %0d cycles %0d edges want %0d cycles %0d edges",
                         cap_busy, cap_tog.size(), exp_busy, exp_tog.size());
    end
  endtask

  task automatic test_reset_mid_burst;
    write_cfg(100, 8, 1'b1, 1'b1);
    bus.i_start_n = 1'b0;
    @(negedge i_clk);
    bus.i_start_n = 1'b1;
    repeat (130) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_clk !== 1'b0 || bus.o_sample !== 1'b0 || bus.o_shift !== 1'b0) begin
      errors++; $display("FAIL async_reset got ready=%b clk=%b smp=%b shf=%b want 1 0 0 0",
                         bus.o_ready, bus.o_clk, bus.o_sample, bus.o_shift);
    end
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    build_expect(2, 8, 0);
    capture(exp_busy + 20, 1'b0, -1);
    checks++;
    if (cap_busy != exp_busy || qdiff(cap_tog, exp_tog) != -1) begin
      errors++; $display("FAIL default_cfg got %0d cycles %0d edges want %0d cycles %0d edges",
                         cap_busy, cap_tog.size(), exp_busy, exp_tog.size());
    end
    checks++;
    if (qdiff(cap_samp, exp_samp) != -1 || cap_end_clk !== 1'b0) begin
      errors++; $display("FAIL default_mode got %0d samples end_clk=%b want %0d samples end_clk=0",
                         cap_samp.size(), cap_end_clk, exp_samp.size());
    end
  endtask

  initial begin
    bus.i_cfg_we   = 1'b0;
    bus.i_cfg_div  = '0;
    bus.i_cfg_len  = '0;
    bus.i_cfg_cpol = 1'b0;
    bus.i_cfg_cpha = 1'b0;
    bus.i_start_n  = 1'b1;
    bus.i_abort    = 1'b0;
    test_reset();
    test_bursts();
    test_config_busy();
    test_back_to_back();
    test_len_zero();
    test_abort();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
